// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, memory-port arbiter state and owner
// encodings, and the data word returned on a timed-out access.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

    // Saturating 4-bit increment used for the DM grant streak.
    function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
        if (val >= lim) begin
            return lim;
        end else begin
            return val + 4'd1;
        end
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for the memory-port arbiter: cleared on load, advanced on inc,
// terminal count flags the last permitted wait cycle before a timeout.
module mem_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic tc
);

    logic [7:0] count_r;

    // Wait-cycle counter; load takes priority over increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= 8'd0;
        end else if (inc) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// the EX/MEM data access, one access at a time, with a timeout watchdog.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int TIMEOUT       = 15,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ready,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              bus_err
);

    arb_state_e        state_r,     state_nxt_s;
    arb_owner_e        owner_r,     owner_nxt_s;
    logic [3:0]        streak_r,    streak_nxt_s;
    logic              ext_req_r,   ext_req_nxt_s;
    logic              ext_we_r,    ext_we_nxt_s;
    logic [ADDR_W-1:0] ext_addr_r,  ext_addr_nxt_s;
    logic [DATA_W-1:0] ext_wdata_r, ext_wdata_nxt_s;
    logic [DATA_W-1:0] if_rdata_r,  if_rdata_nxt_s;
    logic [DATA_W-1:0] dm_rdata_r,  dm_rdata_nxt_s;
    logic              if_valid_r,  if_valid_nxt_s;
    logic              dm_valid_r,  dm_valid_nxt_s;
    logic              bus_err_r,   bus_err_nxt_s;
    logic              tmr_load_s,  tmr_inc_s, tmr_tc_s;
    logic              dm_req_s,    if_forced_s;

    // A simultaneous read and write request is issued as a write.
    assign dm_req_s    = dm_read | dm_write;
    assign if_forced_s = if_req & (streak_r == 4'(MAX_DM_STREAK));

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load_s),
        .inc  (tmr_inc_s),
        .tc   (tmr_tc_s)
    );

    // Next-state, grant and response decode.
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        streak_nxt_s    = streak_r;
        ext_req_nxt_s   = ext_req_r;
        ext_we_nxt_s    = ext_we_r;
        ext_addr_nxt_s  = ext_addr_r;
        ext_wdata_nxt_s = ext_wdata_r;
        if_rdata_nxt_s  = if_rdata_r;
        dm_rdata_nxt_s  = dm_rdata_r;
        if_valid_nxt_s  = 1'b0;
        dm_valid_nxt_s  = 1'b0;
        bus_err_nxt_s   = 1'b0;
        tmr_load_s      = 1'b0;
        tmr_inc_s       = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (dm_req_s && !if_forced_s) begin
                    state_nxt_s    = ARB_BUSY;
                    owner_nxt_s    = OWN_DM;
                    ext_req_nxt_s  = 1'b1;
                    ext_we_nxt_s   = dm_write;
                    ext_addr_nxt_s = dm_addr;
                    tmr_load_s     = 1'b1;
                    if (dm_write) begin
                        ext_wdata_nxt_s = dm_wdata;
                    end else begin
                        ext_wdata_nxt_s = ext_wdata_r;
                    end
                    if (if_req) begin
                        streak_nxt_s = sat_inc4(streak_r, 4'(MAX_DM_STREAK));
                    end else begin
                        streak_nxt_s = streak_r;
                    end
                end else if (if_req) begin
                    state_nxt_s    = ARB_BUSY;
                    owner_nxt_s    = OWN_IF;
                    ext_req_nxt_s  = 1'b1;
                    ext_we_nxt_s   = 1'b0;
                    ext_addr_nxt_s = if_addr;
                    streak_nxt_s   = 4'd0;
                    tmr_load_s     = 1'b1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (ext_ready) begin
                    state_nxt_s   = ARB_RESP;
                    ext_req_nxt_s = 1'b0;
                    if (owner_r == OWN_DM) begin
                        dm_valid_nxt_s = 1'b1;
                        if (!ext_we_r) begin
                            dm_rdata_nxt_s = ext_rdata;
                        end else begin
                            dm_rdata_nxt_s = dm_rdata_r;
                        end
                    end else begin
                        if_valid_nxt_s = 1'b1;
                        if_rdata_nxt_s = ext_rdata;
                    end
                end else if (tmr_tc_s) begin
                    state_nxt_s   = ARB_RESP;
                    ext_req_nxt_s = 1'b0;
                    bus_err_nxt_s = 1'b1;
                    if (owner_r == OWN_DM) begin
                        dm_valid_nxt_s = 1'b1;
                        dm_rdata_nxt_s = ERR_DATA;
                    end else begin
                        if_valid_nxt_s = 1'b1;
                        if_rdata_nxt_s = ERR_DATA;
                    end
                end else begin
                    tmr_inc_s = 1'b1;
                end
            end
            ARB_RESP: begin
                state_nxt_s = ARB_IDLE;
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ARB_IDLE;
            owner_r     <= OWN_IF;
            streak_r    <= 4'd0;
            ext_req_r   <= 1'b0;
            ext_we_r    <= 1'b0;
            ext_addr_r  <= 16'h0000;
            ext_wdata_r <= 16'h0000;
            if_rdata_r  <= 16'h0000;
            dm_rdata_r  <= 16'h0000;
            if_valid_r  <= 1'b0;
            dm_valid_r  <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            streak_r    <= streak_nxt_s;
            ext_req_r   <= ext_req_nxt_s;
            ext_we_r    <= ext_we_nxt_s;
            ext_addr_r  <= ext_addr_nxt_s;
            ext_wdata_r <= ext_wdata_nxt_s;
            if_rdata_r  <= if_rdata_nxt_s;
            dm_rdata_r  <= dm_rdata_nxt_s;
            if_valid_r  <= if_valid_nxt_s;
            dm_valid_r  <= dm_valid_nxt_s;
            bus_err_r   <= bus_err_nxt_s;
        end
    end

    assign ext_req   = ext_req_r;
    assign ext_we    = ext_we_r;
    assign ext_addr  = ext_addr_r;
    assign ext_wdata = ext_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_valid  = if_valid_r;
    assign dm_valid  = dm_valid_r;
    assign bus_err   = bus_err_r;

    // Stalls follow the live requests so the pipeline advances on the valid edge.
    assign if_stall = if_req & ~if_valid_r;
    assign dm_stall = dm_req_s & ~dm_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;

    localparam int TMO  = 15;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic [15:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_read = 1'b0, dm_write = 1'b0;
    logic [15:0] dm_addr = 16'h0000, dm_wdata = 16'h0000;
    logic [15:0] dm_rdata;
    logic        dm_valid, dm_stall;
    logic        ext_req, ext_we;
    logic [15:0] ext_addr, ext_wdata;
    logic        ext_ready = 1'b0;
    logic [15:0] ext_rdata = 16'h0000;
    logic        bus_err;

    int          checks = 0, failures = 0, cyc = 0;
    logic        req_prev = 1'b0, grant_seen = 1'b0;
    int          req_len = 0, mem_wait = 0, mem_delay = 0, next_delay = 0;
    logic        use_fixed = 1'b0, manual_ready = 1'b0;
    logic [15:0] fixed_data = 16'h0000, manual_data = 16'h0000, dm_exp = 16'h0000;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TMO), .MAX_DM_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(ext_ready), .ext_rdata(ext_rdata), .bus_err(bus_err)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // One clock: advance, observe the bus and play the memory for this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        grant_seen = ext_req && !req_prev;
        req_prev   = ext_req;
        if (grant_seen) begin
            req_len   = 0;
            mem_delay = (ext_we && next_delay >= TMO) ? 0 : next_delay;
        end
        if (ext_req) req_len++;
        ext_ready = 1'b0;
        if (ext_req) begin
            if (mem_wait == mem_delay) begin
                ext_ready = 1'b1;
                ext_rdata = use_fixed ? fixed_data : mem_word(ext_addr);
            end
            mem_wait++;
        end else begin
            mem_wait = 0;
        end
        if (manual_ready) begin
            ext_ready = 1'b1;
            ext_rdata = manual_data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({ext_req, ext_we, ext_addr, ext_wdata, if_rdata, dm_rdata, if_valid, dm_valid, bus_err} !== 70'd0)
            begin failures++; $display("FAIL reset_outputs got=%h exp=0",
                {ext_req, ext_we, ext_addr, ext_wdata, if_rdata, dm_rdata, if_valid, dm_valid, bus_err}); end
        if_req = 1'b1; dm_write = 1'b1;
        #1;
        checks++;
        if ({if_stall, dm_stall} !== 2'b11) begin failures++; $display("FAIL reset_stalls got=%b exp=11", {if_stall, dm_stall}); end
        if_req = 1'b0; dm_write = 1'b0;
        #1;
        checks++;
        if ({if_stall, dm_stall} !== 2'b00) begin failures++; $display("FAIL idle_stalls got=%b exp=00", {if_stall, dm_stall}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        int g = -1, v = -1;
        next_delay = 2; use_fixed = 1'b1; fixed_data = 16'h1234;
        if_addr = 16'h0100; if_req = 1'b1;
        for (int i = 0; i < 20 && v < 0; i++) begin
            tick();
            if (grant_seen && g < 0) begin
                g = cyc;
                checks++;
                if (ext_we !== 1'b0 || ext_addr !== 16'h0100 || if_stall !== 1'b1)
                    begin failures++; $display("FAIL if_read_grant got=%b/%h/%b exp=0/0100/1", ext_we, ext_addr, if_stall); end
            end
            if (if_valid) begin
                v = cyc;
                checks++;
                if (if_rdata !== 16'h1234 || if_stall !== 1'b0 || bus_err !== 1'b0)
                    begin failures++; $display("FAIL if_read_resp got=%h/%b/%b exp=1234/0/0", if_rdata, if_stall, bus_err); end
                checks++;
                if (req_len !== 3 || v - g !== 3)
                    begin failures++; $display("FAIL if_read_timing got=req%0d/lat%0d exp=req3/lat3", req_len, v - g); end
                if_req = 1'b0;
            end
        end
        checks++;
        if (v < 0) begin failures++; $display("FAIL if_read_wait got=none exp=if_valid"); end
        use_fixed = 1'b0;
        if_req = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b0) begin failures++; $display("FAIL if_valid_pulse got=%b exp=0", if_valid); end
    endtask

    task automatic test_dm_write();
        int g = -1, v = -1;
        next_delay = 0;
        dm_addr = 16'h0040; dm_wdata = 16'hBEEF; dm_write = 1'b1;
        for (int i = 0; i < 20 && v < 0; i++) begin
            tick();
            if (grant_seen && g < 0) begin
                g = cyc;
                checks++;
                if (ext_we !== 1'b1 || ext_addr !== 16'h0040 || ext_wdata !== 16'hBEEF)
                    begin failures++; $display("FAIL dm_write_grant got=%b/%h/%h exp=1/0040/beef", ext_we, ext_addr, ext_wdata); end
            end
            if (dm_valid) begin
                v = cyc;
                checks++;
                if (dm_rdata !== dm_exp || bus_err !== 1'b0 || dm_stall !== 1'b0 || v - g !== 1)
                    begin failures++; $display("FAIL dm_write_resp got=%h/%b/%b/%0d exp=%h/0/0/1", dm_rdata, bus_err, dm_stall, v - g, dm_exp); end
                dm_write = 1'b0;
            end
        end
        checks++;
        if (v < 0) begin failures++; $display("FAIL dm_write_wait got=none exp=dm_valid"); end
        dm_write = 1'b0;
        tick();
    endtask

    task automatic test_streak();
        int n = 0, last_g = -1, done = 0;
        logic exp_if;
        next_delay = 0;
        if_addr = 16'h1000; if_req = 1'b1;
        dm_addr = 16'h2000; dm_read = 1'b1;
        for (int i = 0; i < 80 && done == 0; i++) begin
            tick();
            if (grant_seen) begin
                exp_if = (n % 5 == 4);
                checks++;
                if (ext_addr !== (exp_if ? 16'h1000 : 16'h2000))
                    begin failures++; $display("FAIL streak_order grant%0d got=%h exp=%h", n, ext_addr, exp_if ? 16'h1000 : 16'h2000); end
                if (last_g >= 0) begin
                    checks++;
                    if (cyc - last_g !== 3) begin failures++; $display("FAIL streak_spacing got=%0d exp=3", cyc - last_g); end
                end
                last_g = cyc;
                n++;
            end
            if (dm_valid) begin
                dm_exp = mem_word(16'h2000);
                checks++;
                if (dm_rdata !== dm_exp) begin failures++; $display("FAIL streak_dm_rdata got=%h exp=%h", dm_rdata, dm_exp); end
            end
            if (n >= 10 && if_valid) begin
                if_req = 1'b0; dm_read = 1'b0; done = 1;
            end
        end
        checks++;
        if (done == 0) begin failures++; $display("FAIL streak_wait got=%0d exp=10", n); end
        if_req = 1'b0; dm_read = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int g = -1, v = -1, g2 = -1;
        next_delay = 1000;
        if_addr = 16'h0300; if_req = 1'b1;
        for (int i = 0; i < 40 && v < 0; i++) begin
            tick();
            if (grant_seen && g < 0) g = cyc;
            if (if_valid) begin
                v = cyc;
                checks++;
                if (if_rdata !== 16'hFFFF || bus_err !== 1'b1)
                    begin failures++; $display("FAIL timeout_resp got=%h/%b exp=ffff/1", if_rdata, bus_err); end
                checks++;
                if (req_len !== TMO || v - g !== TMO)
                    begin failures++; $display("FAIL timeout_len got=req%0d/lat%0d exp=%0d", req_len, v - g, TMO); end
                if_req = 1'b0;
                dm_addr = 16'h0310; dm_read = 1'b1; next_delay = 0;
            end
        end
        checks++;
        if (v < 0) begin failures++; $display("FAIL timeout_wait got=none exp=if_valid"); end
        for (int i = 0; i < 10 && g2 < 0; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if ({bus_err, if_valid} !== 2'b00) begin failures++; $display("FAIL timeout_pulse got=%b exp=00", {bus_err, if_valid}); end
            end
            if (grant_seen) g2 = cyc;
        end
        checks++;
        if (g2 - v !== 2) begin failures++; $display("FAIL timeout_idle_next got=%0d exp=2", g2 - v); end
        for (int i = 0; i < 10 && dm_read; i++) begin
            tick();
            if (dm_valid) begin dm_exp = dm_rdata; dm_read = 1'b0; end
        end
        dm_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight();
        int v = -1;
        next_delay = 1000;
        dm_addr = 16'h0500; dm_read = 1'b1;
        for (int i = 0; i < 10 && !grant_seen; i++) tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({ext_req, ext_we, ext_addr, ext_wdata, if_rdata, dm_rdata, if_valid, dm_valid, bus_err} !== 70'd0 || dm_stall !== 1'b1)
            begin failures++; $display("FAIL midflight_reset got=%b/%h/%b exp=0/0/1", ext_req, dm_rdata, dm_stall); end
        manual_ready = 1'b1; manual_data = 16'hDEAD;
        tick();
        checks++;
        if ({ext_req, dm_valid, bus_err} !== 3'b000) begin failures++; $display("FAIL midflight_hold got=%b exp=000", {ext_req, dm_valid, bus_err}); end
        dm_exp = 16'h0000;
        rst = 1'b1; manual_ready = 1'b0; next_delay = 1;
        tick();
        checks++;
        if (grant_seen !== 1'b1 || ext_addr !== 16'h0500 || dm_valid !== 1'b0)
            begin failures++; $display("FAIL midflight_regrant got=%b/%h/%b exp=1/0500/0", grant_seen, ext_addr, dm_valid); end
        for (int i = 0; i < 10 && v < 0; i++) begin
            tick();
            if (dm_valid) begin
                v = i;
                dm_exp = mem_word(16'h0500);
                checks++;
                if (dm_rdata !== dm_exp || req_len !== 2)
                    begin failures++; $display("FAIL midflight_resp got=%h/req%0d exp=%h/req2", dm_rdata, req_len, dm_exp); end
                dm_read = 1'b0;
            end
        end
        checks++;
        if (v < 0) begin failures++; $display("FAIL midflight_wait got=none exp=dm_valid"); end
        dm_read = 1'b0;
        tick();
    endtask

    task automatic test_idle_ready_rw();
        int v = -1;
        manual_ready = 1'b1; manual_data = 16'h1111;
        tick();
        manual_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({ext_req, if_valid, dm_valid, bus_err} !== 4'b0000)
                begin failures++; $display("FAIL idle_ready got=%b exp=0000", {ext_req, if_valid, dm_valid, bus_err}); end
        end
        next_delay = 0;
        dm_addr = 16'h0600; dm_wdata = 16'h5555; dm_read = 1'b1; dm_write = 1'b1;
        for (int i = 0; i < 10 && v < 0; i++) begin
            tick();
            if (grant_seen) begin
                checks++;
                if (ext_we !== 1'b1 || ext_addr !== 16'h0600 || ext_wdata !== 16'h5555)
                    begin failures++; $display("FAIL rw_as_write got=%b/%h/%h exp=1/0600/5555", ext_we, ext_addr, ext_wdata); end
            end
            if (dm_valid) begin
                v = i;
                checks++;
                if (dm_rdata !== dm_exp) begin failures++; $display("FAIL rw_rdata got=%h exp=%h", dm_rdata, dm_exp); end
                dm_read = 1'b0; dm_write = 1'b0;
            end
        end
        checks++;
        if (v < 0) begin failures++; $display("FAIL rw_wait got=none exp=dm_valid"); end
        dm_read = 1'b0; dm_write = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int own_m = 0, streak_m = 0, exp_v = 0, d = 0, r = 0;
        logic we_m, exp_e, ifp, dmp, if_resp, dm_resp, raise;
        logic [15:0] a_m, w_m, exp_d;
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        dm_exp = 16'h0000;
        for (int n = 0; n < 700; n++) begin
            tick();
            raise = (n < 600);
            if (grant_seen) begin
                ifp = if_req; dmp = dm_read | dm_write;
                checks++;
                if (own_m != 0) begin failures++; $display("FAIL rand_overlap got=grant exp=busy_owner%0d", own_m); end
                if (dmp && !(ifp && streak_m == MAXS)) begin
                    own_m = 2; we_m = dm_write; a_m = dm_addr; w_m = dm_wdata;
                    if (ifp && streak_m < MAXS) streak_m++;
                end else begin
                    own_m = 1; we_m = 1'b0; a_m = if_addr; w_m = ext_wdata;
                    streak_m = 0;
                end
                checks++;
                if (ext_addr !== a_m || ext_we !== we_m || (we_m && ext_wdata !== w_m))
                    begin failures++; $display("FAIL rand_grant got=%h/%b/%h exp=%h/%b/%h", ext_addr, ext_we, ext_wdata, a_m, we_m, w_m); end
                d = (we_m && next_delay >= TMO) ? 0 : next_delay;
                exp_e = (d >= TMO);
                exp_v = cyc + (exp_e ? TMO : d + 1);
                if (exp_e) exp_d = 16'hFFFF;
                else if (own_m == 2 && we_m) exp_d = dm_exp;
                else exp_d = mem_word(a_m);
            end
            if_resp = 1'b0; dm_resp = 1'b0;
            checks++;
            if (own_m != 0 && cyc == exp_v) begin
                if (own_m == 1) begin
                    if_resp = 1'b1;
                    if (if_valid !== 1'b1 || dm_valid !== 1'b0 || if_rdata !== exp_d || bus_err !== exp_e)
                        begin failures++; $display("FAIL rand_if_resp got=%b/%h/%b exp=1/%h/%b", if_valid, if_rdata, bus_err, exp_d, exp_e); end
                end else begin
                    dm_resp = 1'b1;
                    dm_exp = exp_d;
                    if (dm_valid !== 1'b1 || if_valid !== 1'b0 || dm_rdata !== exp_d || bus_err !== exp_e)
                        begin failures++; $display("FAIL rand_dm_resp got=%b/%h/%b exp=1/%h/%b", dm_valid, dm_rdata, bus_err, exp_d, exp_e); end
                end
                own_m = 0;
            end else if ({if_valid, dm_valid, bus_err} !== 3'b000) begin
                failures++; $display("FAIL rand_spurious got=%b exp=000 cyc=%0d", {if_valid, dm_valid, bus_err}, cyc);
            end
            if (!if_req || if_resp) begin
                if_req = raise && ($urandom_range(0, 2) == 0);
                if_addr = 16'($urandom);
            end
            if (!(dm_read | dm_write) || dm_resp) begin
                r = int'($urandom_range(0, 5));
                dm_read  = raise && (r == 3 || r == 5);
                dm_write = raise && (r == 4 || r == 5);
                dm_addr  = 16'($urandom);
                dm_wdata = 16'($urandom);
            end
            r = int'($urandom_range(0, 11));
            next_delay = (r == 0) ? 100 : (r == 1) ? TMO - 1 : (r == 2) ? TMO : int'($urandom_range(0, 3));
        end
        checks++;
        if (own_m != 0 || if_req || dm_read || dm_write)
            begin failures++; $display("FAIL rand_drain got=owner%0d exp=owner0", own_m); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_streak();
        test_timeout();
        test_reset_midflight();
        test_idle_ready_rw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
